// File: rtl/wallace_tree_mult.sv
// rtl/wallace_tree_mult.sv - unsigned 16x16 Wallace-tree multiplier with registered 32-bit product
//
// Purpose:
//    Forms 16 partial-product rows, reduces them with layers of 3:2
//    compressors (16 -> 11 -> 8 -> 6 -> 4 -> 3 -> 2 rows), then sums the two
//    surviving rows in a single carry-propagate adder. The product and the
//    adder carry-out are registered, giving one cycle of latency at one
//    result per cycle.
//
// Ports:
//    clk    in   1   rising-edge clock
//    rst_n  in   1   asynchronous active-low reset, clears C and carry
//    A      in   16  multiplicand, unsigned
//    B      in   16  multiplier, unsigned
//    C      out  32  registered product A*B
//    carry  out  1   registered carry-out of the final adder (bit 32)

module wallace_tree_mult (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] A,
   input  logic [15:0] B,
   output logic [31:0] C,
   output logic        carry
);

   // Bitwise full adder across all 32 columns. The majority term moves up
   // one column; its top bit is never needed because the rows always sum to
   // the exact product, which fits in 32 bits.
   function automatic logic [63:0] csa(input logic [31:0] x,
                                       input logic [31:0] y,
                                       input logic [31:0] z);
      logic [31:0] s;
      logic [31:0] m;
      s = x ^ y ^ z;
      m = {(x[30:0] & y[30:0]) | (x[30:0] & z[30:0]) | (y[30:0] & z[30:0]), 1'b0};
      return {m, s};
   endfunction

   logic [31:0] l0 [16];
   logic [31:0] l1 [11];
   logic [31:0] l2 [8];
   logic [31:0] l3 [6];
   logic [31:0] l4 [4];
   logic [31:0] l5 [3];
   logic [31:0] l6 [2];
   logic [32:0] final_sum;

   // Partial-product rows: row i is A gated by B[i], weighted by 2^i.
   always_comb begin
      for (int i = 0; i < 16; i++) begin
         l0[i] = {16'h0000, A & {16{B[i]}}} << i;
      end
   end

   // Reduction tree. Each level compresses groups of three rows into two
   // and passes any leftover rows straight through to the next level.
   always_comb begin
      for (int g = 0; g < 5; g++) begin
         {l1[2*g+1], l1[2*g]} = csa(l0[3*g], l0[3*g+1], l0[3*g+2]);
      end
      l1[10] = l0[15];

      for (int g = 0; g < 3; g++) begin
         {l2[2*g+1], l2[2*g]} = csa(l1[3*g], l1[3*g+1], l1[3*g+2]);
      end
      l2[6] = l1[9];
      l2[7] = l1[10];

      for (int g = 0; g < 2; g++) begin
         {l3[2*g+1], l3[2*g]} = csa(l2[3*g], l2[3*g+1], l2[3*g+2]);
      end
      l3[4] = l2[6];
      l3[5] = l2[7];

      for (int g = 0; g < 2; g++) begin
         {l4[2*g+1], l4[2*g]} = csa(l3[3*g], l3[3*g+1], l3[3*g+2]);
      end

      {l5[1], l5[0]} = csa(l4[0], l4[1], l4[2]);
      l5[2] = l4[3];

      {l6[1], l6[0]} = csa(l5[0], l5[1], l5[2]);
   end

   // Final carry-propagate adder; bit 32 is kept as a self-check flag and
   // should always be zero.
   assign final_sum = {1'b0, l6[0]} + {1'b0, l6[1]};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         C     <= 32'h0000_0000;
         carry <= 1'b0;
      end else begin
         C     <= final_sum[31:0];
         carry <= final_sum[32];
      end
   end

endmodule

// File: tb/tb_wallace_tree_mult.sv
// tb/tb_wallace_tree_mult.sv - self-checking bench for wallace_tree_mult

module tb_wallace_tree_mult;

   logic        clk;
   logic        rst_n;
   logic [15:0] A;
   logic [15:0] B;
   logic [31:0] C;
   logic        carry;

   int tests_run;
   int tests_failed;

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic [31:0] exp_c;
   } vec_t;

   vec_t vecs [14];
   logic [15:0] corners [5];

   wallace_tree_mult dut (
      .clk   (clk),
      .rst_n (rst_n),
      .A     (A),
      .B     (B),
      .C     (C),
      .carry (carry)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] exp_c);
      tests_run++;
      if (C !== exp_c || carry !== 1'b0) begin
         tests_failed++;
         $display("FAIL %s: got C=%08h carry=%b, expected C=%08h carry=0",
                  name, C, carry, exp_c);
      end
   endtask

   // Drive operands mid-cycle, then sample 1 time unit after the loading edge.
   task automatic apply(input logic [15:0] a, input logic [15:0] b,
                        input logic [31:0] exp_c, input string name);
      @(negedge clk);
      A = a;
      B = b;
      @(posedge clk);
      #1;
      check(name, exp_c);
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;

      vecs[0]  = '{16'h0000, 16'h0000, 32'h0000_0000};
      vecs[1]  = '{16'h0001, 16'h0001, 32'h0000_0001};
      vecs[2]  = '{16'h8000, 16'h0002, 32'h0001_0000};
      vecs[3]  = '{16'h1234, 16'hABCD, 32'h0C37_4FA4};
      vecs[4]  = '{16'h0F0F, 16'h00FF, 32'h000E_FFF1};
      vecs[5]  = '{16'hFFFF, 16'hFFFF, 32'hFFFE_0001};
      vecs[6]  = '{16'h0001, 16'hFFFF, 32'h0000_FFFF};
      vecs[7]  = '{16'h8000, 16'h8000, 32'h4000_0000};
      vecs[8]  = '{16'h7FFF, 16'h7FFF, 32'h3FFF_0001};
      vecs[9]  = '{16'h0010, 16'h1234, 32'h0001_2340};
      vecs[10] = '{16'hFFFF, 16'h0000, 32'h0000_0000};
      vecs[11] = '{16'h7FFF, 16'hFFFF, 32'h7FFE_8001};
      vecs[12] = '{16'h8000, 16'hFFFF, 32'h7FFF_8000};
      vecs[13] = '{16'h0100, 16'h0100, 32'h0001_0000};

      corners[0] = 16'h0000;
      corners[1] = 16'h0001;
      corners[2] = 16'h7FFF;
      corners[3] = 16'h8000;
      corners[4] = 16'hFFFF;

      // Reset held low with maximal operands: outputs must stay cleared.
      rst_n = 1'b0;
      A     = 16'hFFFF;
      B     = 16'hFFFF;
      #1;
      check("reset_initial", 32'h0000_0000);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         check("reset_held", 32'h0000_0000);
      end

      // First edge after release loads a real product.
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("first_after_reset", 32'hFFFE_0001);

      // Directed table, applied back to back on consecutive edges.
      for (int i = 0; i < 14; i++) begin
         apply(vecs[i].a, vecs[i].b, vecs[i].exp_c, $sformatf("vec%0d", i));
      end

      // Operands changing after the edge must not disturb the held result.
      apply(16'h1234, 16'hABCD, 32'h0C37_4FA4, "hold_setup");
      #2;
      A = 16'h0003;
      B = 16'h0005;
      #1;
      check("hold_between_edges", 32'h0C37_4FA4);
      @(posedge clk);
      #1;
      check("hold_next_edge", 32'h0000_000F);

      // Asynchronous reset between edges while C is nonzero.
      apply(16'hFFFF, 16'hFFFF, 32'hFFFE_0001, "async_setup");
      #2;
      rst_n = 1'b0;
      #1;
      check("async_reset", 32'h0000_0000);
      @(posedge clk);
      #1;
      check("async_reset_hold", 32'h0000_0000);
      @(negedge clk);
      rst_n = 1'b1;
      apply(16'h0F0F, 16'h00FF, 32'h000E_FFF1, "after_async_reset");

      // Corner values in all pairings.
      for (int i = 0; i < 5; i++) begin
         for (int j = 0; j < 5; j++) begin
            apply(corners[i], corners[j], 32'(corners[i]) * 32'(corners[j]),
                  $sformatf("corner_%04h_%04h", corners[i], corners[j]));
         end
      end

      // Random operand pairs against the unsigned reference product.
      for (int k = 0; k < 1000; k++) begin
         logic [15:0] ra;
         logic [15:0] rb;
         ra = 16'($urandom_range(0, 65535));
         rb = 16'($urandom_range(0, 65535));
         apply(ra, rb, 32'(ra) * 32'(rb), $sformatf("rand_%04h_%04h", ra, rb));
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
